// File: rtl/uart_bridge_avm_master.sv
`default_nettype none
// ============================================================================
// Module      : uart_bridge_avm_master
// Description : Avalon-MM initiator driven by framed UART command bytes.
//               Decodes write/read frames, performs one single-word bus
//               access at a time and returns response bytes (81 / 82+data /
//               FF bad opcode / EE timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bridge_avm_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    // Counter is wide enough to hold TIMEOUT itself, so an increment past the
    // limit (read accepted on the limit cycle) is still caught in RD_WAIT.
    localparam int              c_TW     = $clog2(TIMEOUT + 2);
    localparam logic [c_TW-1:0] c_TLIM   = c_TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [7:0]      c_OP_WR  = 8'h01;
    localparam logic [7:0]      c_OP_RD  = 8'h02;
    localparam logic [7:0]      c_RSP_WR = 8'h81;
    localparam logic [7:0]      c_RSP_RD = 8'h82;
    localparam logic [7:0]      c_RSP_BAD = 8'hFF;
    localparam logic [7:0]      c_RSP_TMO = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WDATA   = 3'd2,
        S_BUS_WR  = 3'd3,
        S_BUS_RD  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    state_t          r_state,      w_state_nxt;
    logic            r_is_read,    w_is_read_nxt;
    logic [1:0]      r_cnt,        w_cnt_nxt;
    logic [31:0]     r_addr,       w_addr_nxt;
    logic [31:0]     r_wdata,      w_wdata_nxt;
    logic [31:0]     r_shift,      w_shift_nxt;
    logic [2:0]      r_left,       w_left_nxt;
    logic [c_TW-1:0] r_tcnt,       w_tcnt_nxt;
    logic            r_avm_read,   w_avm_read_nxt;
    logic            r_avm_write,  w_avm_write_nxt;
    logic            r_out_valid,  w_out_valid_nxt;
    logic [7:0]      r_out_data,   w_out_data_nxt;
    logic            w_tmo;

    assign w_tmo          = (TIMEOUT != 0) && (r_tcnt >= c_TLIM);
    assign in_ready       = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_WDATA);
    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign avm_address    = r_addr[ADDR_W-1:0];
    assign avm_read       = r_avm_read;
    assign avm_write      = r_avm_write;
    assign avm_writedata  = r_wdata;
    assign avm_byteenable = 4'hF;

    // Next-state and next-register-value decode; everything holds by default.
    always_comb begin
        w_state_nxt     = r_state;
        w_is_read_nxt   = r_is_read;
        w_cnt_nxt       = r_cnt;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_shift_nxt     = r_shift;
        w_left_nxt      = r_left;
        w_tcnt_nxt      = r_tcnt;
        w_avm_read_nxt  = r_avm_read;
        w_avm_write_nxt = r_avm_write;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if ((in_data == c_OP_WR) || (in_data == c_OP_RD)) begin
                        w_is_read_nxt = (in_data == c_OP_RD);
                        w_cnt_nxt     = 2'd0;
                        w_state_nxt   = S_ADDR;
                    end else begin
                        w_out_data_nxt  = c_RSP_BAD;
                        w_out_valid_nxt = 1'b1;
                        w_left_nxt      = 3'd0;
                        w_state_nxt     = S_RESP;
                    end
                end
            end

            S_ADDR: begin
                if (in_valid) begin
                    w_addr_nxt = {r_addr[23:0], in_data};
                    w_cnt_nxt  = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        if (r_is_read) begin
                            w_avm_read_nxt = 1'b1;
                            w_tcnt_nxt     = '0;
                            w_state_nxt    = S_BUS_RD;
                        end else begin
                            w_state_nxt    = S_WDATA;
                        end
                    end
                end
            end

            S_WDATA: begin
                if (in_valid) begin
                    w_wdata_nxt = {r_wdata[23:0], in_data};
                    w_cnt_nxt   = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_avm_write_nxt = 1'b1;
                        w_tcnt_nxt      = '0;
                        w_state_nxt     = S_BUS_WR;
                    end
                end
            end

            S_BUS_WR: begin
                // Completion is tested before the limit so it wins a tie.
                if (!avm_waitrequest) begin
                    w_avm_write_nxt = 1'b0;
                    w_out_data_nxt  = c_RSP_WR;
                    w_out_valid_nxt = 1'b1;
                    w_left_nxt      = 3'd0;
                    w_state_nxt     = S_RESP;
                end else if (w_tmo) begin
                    w_avm_write_nxt = 1'b0;
                    w_out_data_nxt  = c_RSP_TMO;
                    w_out_valid_nxt = 1'b1;
                    w_left_nxt      = 3'd0;
                    w_state_nxt     = S_RESP;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end

            S_BUS_RD: begin
                // readdatavalid is deliberately not looked at here, so a
                // strobe coincident with acceptance is ignored.
                if (!avm_waitrequest) begin
                    w_avm_read_nxt = 1'b0;
                    w_tcnt_nxt     = r_tcnt + 1'b1;
                    w_state_nxt    = S_RD_WAIT;
                end else if (w_tmo) begin
                    w_avm_read_nxt  = 1'b0;
                    w_out_data_nxt  = c_RSP_TMO;
                    w_out_valid_nxt = 1'b1;
                    w_left_nxt      = 3'd0;
                    w_state_nxt     = S_RESP;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end

            S_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    w_shift_nxt     = avm_readdata;
                    w_out_data_nxt  = c_RSP_RD;
                    w_out_valid_nxt = 1'b1;
                    w_left_nxt      = 3'd4;
                    w_state_nxt     = S_RESP;
                end else if (w_tmo) begin
                    w_out_data_nxt  = c_RSP_TMO;
                    w_out_valid_nxt = 1'b1;
                    w_left_nxt      = 3'd0;
                    w_state_nxt     = S_RESP;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end

            S_RESP: begin
                if (out_ready) begin
                    if (r_left != 3'd0) begin
                        w_out_data_nxt = r_shift[31:24];
                        w_shift_nxt    = {r_shift[23:0], 8'h00};
                        w_left_nxt     = r_left - 3'd1;
                    end else begin
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_is_read   <= 1'b0;
            r_cnt       <= 2'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_shift     <= 32'd0;
            r_left      <= 3'd0;
            r_tcnt      <= '0;
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_is_read   <= w_is_read_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_shift     <= w_shift_nxt;
            r_left      <= w_left_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_avm_read  <= w_avm_read_nxt;
            r_avm_write <= w_avm_write_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_bridge_avm_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_bridge_avm_master
// Description : Scoreboard bench for uart_bridge_avm_master. Expected response
//               bytes and bus accesses are queued as frames are sent; monitors
//               pop and compare when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_bridge_avm_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [7:0]  exp_q[$];
    wr_t         exp_wr_q[$];
    logic [31:0] exp_rd_q[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          last_wlen = 0;
    int          last_rlen = 0;

    logic        bp_mode = 1'b0;
    logic [3:0]  bp_pat  = 4'b1001;
    int          rd_delay = 2;
    logic        rd_spurious = 1'b0;
    logic [31:0] rd_data = 32'h0;

    uart_bridge_avm_master #(
        .ADDR_W  (32),
        .TIMEOUT (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic push_bytes(input logic [7:0] b0, input int n, input logic [31:0] d);
        exp_q.push_back(b0);
        if (n > 1) begin
            exp_q.push_back(d[31:24]);
            exp_q.push_back(d[23:16]);
            exp_q.push_back(d[15:8]);
            exp_q.push_back(d[7:0]);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid || exp_wr_q.size() != 0 ||
                exp_rd_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("frame_done_wait", exp_q.size(), 32'd0);
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // out_ready driver: all-ones, or the 1,0,0,1 back-pressure pattern.
    initial begin
        int idx;
        idx = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = bp_pat[idx];
                idx = (idx + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Response monitor: pops expected bytes and checks stability under stall.
    initial begin
        logic       stall_prev;
        logic [7:0] stall_data;
        logic [7:0] e;
        stall_prev = 1'b0;
        stall_data = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("resp_hold_valid", {31'd0, out_valid}, 32'd1);
                    check("resp_hold_data", {24'd0, out_data}, {24'd0, stall_data});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL resp_unexpected: got byte %02h, expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_byte", {24'd0, out_data}, {24'd0, e});
                    end
                end
                stall_prev = out_valid && !out_ready;
                stall_data = out_data;
            end
        end
    end

    // Bus monitor: checks accepted accesses and measures request pulse lengths.
    initial begin
        int  wcnt;
        int  rcnt;
        wr_t w;
        logic [31:0] a;
        wcnt = 0;
        rcnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (avm_read && avm_write) check("rd_wr_exclusive", 32'd1, 32'd0);
                if (avm_write && !avm_waitrequest) begin
                    if (exp_wr_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL wr_unexpected: got write to %0h, expected none", avm_address);
                    end else begin
                        w = exp_wr_q.pop_front();
                        check("wr_addr", avm_address, w.addr);
                        check("wr_data", avm_writedata, w.data);
                        check("wr_be", {28'd0, avm_byteenable}, 32'hF);
                    end
                end
                if (avm_read && !avm_waitrequest) begin
                    if (exp_rd_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL rd_unexpected: got read of %0h, expected none", avm_address);
                    end else begin
                        a = exp_rd_q.pop_front();
                        check("rd_addr", avm_address, a);
                    end
                end
                if (avm_write) wcnt++;
                else if (wcnt != 0) begin last_wlen = wcnt; wcnt = 0; end
                if (avm_read) rcnt++;
                else if (rcnt != 0) begin last_rlen = rcnt; rcnt = 0; end
            end
        end
    end

    // Read-data slave: returns rd_data rd_delay cycles after acceptance,
    // optionally with a bogus strobe in the acceptance cycle itself.
    initial begin
        avm_readdata      = 32'h0;
        avm_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && avm_read && !avm_waitrequest) begin
                if (rd_spurious) begin
                    avm_readdata      = 32'hBAD0BAD0;
                    avm_readdatavalid = 1'b1;
                    @(posedge clk);
                    #1;
                    avm_readdatavalid = 1'b0;
                end else begin
                    @(posedge clk);
                end
                repeat (rd_delay - 1) @(posedge clk);
                #1;
                avm_readdata      = rd_data;
                avm_readdatavalid = 1'b1;
                @(posedge clk);
                #1;
                avm_readdatavalid = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        in_data         = 8'h00;
        in_valid        = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_avm_read", {31'd0, avm_read}, 32'd0);
        check("rst_avm_write", {31'd0, avm_write}, 32'd0);
        check("rst_avm_address", avm_address, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Plain write, no stall.
        exp_wr_q.push_back('{addr: 32'h0, data: 32'h2});
        push_bytes(8'h81, 1, 32'h0);
        send_byte(8'h01); send_word(32'h0); send_word(32'h2);
        wait_idle();
        check("wr_pulse_len", last_wlen, 32'd1);

        // Read with 3 stall cycles, data two cycles after acceptance.
        rd_delay = 2; rd_data = 32'hDEADBEEF;
        exp_rd_q.push_back(32'h4);
        push_bytes(8'h82, 5, 32'hDEADBEEF);
        send_byte(8'h02);
        avm_waitrequest = 1'b1;
        send_word(32'h4);
        check("bus_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        avm_waitrequest = 1'b0;
        wait_idle();
        check("rd_pulse_len", last_rlen, 32'd4);

        // Read response under out_ready back-pressure.
        bp_mode = 1'b1; rd_delay = 3; rd_data = 32'h01234567;
        exp_rd_q.push_back(32'h10);
        push_bytes(8'h82, 5, 32'h01234567);
        send_byte(8'h02); send_word(32'h10);
        wait_idle();
        bp_mode = 1'b0;

        // Bad opcode, then a read with a strobe coinciding with acceptance.
        push_bytes(8'hFF, 1, 32'h0);
        send_byte(8'h55);
        rd_spurious = 1'b1; rd_delay = 1; rd_data = 32'hA55A0FF0;
        exp_rd_q.push_back(32'h8);
        push_bytes(8'h82, 5, 32'hA55A0FF0);
        send_byte(8'h02); send_word(32'h8);
        wait_idle();
        rd_spurious = 1'b0;

        // Completion in the very cycle the limit is reached wins.
        exp_wr_q.push_back('{addr: 32'h20, data: 32'h11223344});
        push_bytes(8'h81, 1, 32'h0);
        send_byte(8'h01); send_word(32'h20);
        avm_waitrequest = 1'b1;
        send_word(32'h11223344);
        repeat (15) @(posedge clk);
        #1;
        avm_waitrequest = 1'b0;
        wait_idle();
        check("limit_wr_len", last_wlen, 32'd16);

        // Stuck waitrequest: abort after 16 cycles with EE.
        push_bytes(8'hEE, 1, 32'h0);
        send_byte(8'h01); send_word(32'h30);
        avm_waitrequest = 1'b1;
        send_word(32'hCAFEF00D);
        wait_idle();
        avm_waitrequest = 1'b0;
        check("tmo_wr_len", last_wlen, 32'd16);

        // Next frame after the abort.
        exp_wr_q.push_back('{addr: 32'h40, data: 32'h55AA55AA});
        push_bytes(8'h81, 1, 32'h0);
        send_byte(8'h01); send_word(32'h40); send_word(32'h55AA55AA);
        wait_idle();

        // Asynchronous reset after two address bytes.
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_data", {24'd0, out_data}, 32'd0);
        check("mid_rst_avm_write", {31'd0, avm_write}, 32'd0);
        check("mid_rst_avm_read", {31'd0, avm_read}, 32'd0);
        check("mid_rst_address", avm_address, 32'd0);
        check("mid_rst_writedata", avm_writedata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_wr_q.push_back('{addr: 32'h4, data: 32'h0000BEEF});
        push_bytes(8'h81, 1, 32'h0);
        send_byte(8'h01); send_word(32'h4); send_word(32'h0000BEEF);
        wait_idle();

        check("final_exp_q_empty", exp_q.size(), 32'd0);
        check("final_wr_q_empty", exp_wr_q.size(), 32'd0);
        check("final_rd_q_empty", exp_rd_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_bridge_avm_master.md
Name: uart_bridge_avm_master

Overview:
Avalon-MM initiator that turns framed command bytes from the UART receive path into single-word Avalon-MM reads and writes. It returns response bytes to the UART transmit path. It sits between the UART byte streams and the bridge interconnect, and drives slaves such as the PIO output registers. Accesses are strictly one at a time, with no pipelining.

Parameters:
ADDR_W, 32, Avalon address width; the upper bits of the received 32-bit address are dropped.
TIMEOUT, 1024, maximum cycles spent in any bus state before the command is aborted; 0 disables the timeout.

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
in_data  in  8  command byte from the UART receiver
in_valid  in  1  in_data is valid
in_ready  out  1  byte accepted when in_valid & in_ready
out_data  out  8  response byte to the UART transmitter
out_valid  out  1  response byte is valid
out_ready  in  1  transmitter consumes the byte when out_valid & out_ready
avm_address  out  ADDR_W  byte address
avm_read  out  1  read request
avm_write  out  1  write request
avm_writedata  out  32  write data
avm_byteenable  out  4  constant 4'hF
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data is valid

Behaviour:
- Reset: the asynchronous assert forces the following values. FSM=IDLE; avm_read=0, avm_write=0, avm_address=0, avm_writedata=0; out_valid=0, out_data=0; the byte counter and timeout counter are 0. in_ready decodes the state, so it reads 1 under reset (state is IDLE).
- Command frame:
  - Opcode byte first: 0x01 = write, 0x02 = read.
  - Then 4 address bytes, MSB first.
  - A write then carries 4 data bytes, MSB first.
- Response frame:
  - Write OK: 0x81.
  - Read OK: 0x82 followed by 4 readdata bytes, MSB first.
  - Bad opcode: 0xFF.
  - Timeout: 0xEE.
- in_ready=1 only in IDLE, ADDR and WDATA. It is 0 in every other state.
- FSM states: IDLE, ADDR, WDATA, BUS_WR, BUS_RD, RD_WAIT, RESP.
- IDLE:
  - Opcode 0x01 or 0x02: latch the opcode and go to ADDR with cnt=0.
  - Any other opcode: load out_data=0xFF and go to RESP with a 1-byte response.
- ADDR: shift each accepted byte into the address (addr = {addr[23:0], byte}).
  - On the 4th byte: write goes to WDATA; read goes to BUS_RD.
  - avm_read rises in the cycle after the 4th byte is accepted.
- WDATA: shift bytes into writedata in the same way. On the 4th byte go to BUS_WR; avm_write rises the next cycle.
- BUS_WR: hold avm_write, address and writedata stable while avm_waitrequest=1.
  - In the first cycle with waitrequest=0: drop avm_write next cycle, go to RESP, and set out_valid=1 with out_data=0x81.
- BUS_RD: hold avm_read while waitrequest=1. When waitrequest=0: drop avm_read and go to RD_WAIT.
- RD_WAIT: wait for avm_readdatavalid.
  - readdatavalid is ignored when it arrives in the same cycle as read acceptance.
  - On readdatavalid: latch readdata into the response shift register and go to RESP with 0x82 as the first byte.
- RESP: hold out_valid and out_data until out_ready.
  - After each handshake, advance to the next byte in the following cycle.
  - After the last byte, set out_valid=0 and go to IDLE. A byte may be accepted in the next cycle.
- Timeout counter: cleared on entry to BUS_WR or BUS_RD, and counts every cycle in BUS_WR, BUS_RD and RD_WAIT.
  - When the count reaches TIMEOUT-1 without completion: deassert avm_read/avm_write, send the 1-byte 0xEE response, then go to IDLE.
  - A completion in the same cycle as the limit wins.
  - The abort is a system-level recovery only. Slaves in this design tolerate it.
- No input bytes are consumed between frames or during the bus phase. The UART RX must buffer them, and the design relies on that.
- Reset mid-frame or mid-bus-cycle: return immediately to the reset values. No response is sent and the partial frame is discarded.
- Width: avm_address = addr[ADDR_W-1:0].

Test Plan:
- Write: bytes 01 00 00 00 00 00 00 00 02, waitrequest=0 → one avm_write pulse with address 0 and writedata 0x00000002 → response 81.
- Read with stall: bytes 02 00 00 00 04, waitrequest=1 for 3 cycles, readdatavalid 2 cycles after acceptance with data 0xDEADBEEF → avm_read held 4 cycles → response 82 DE AD BE EF.
- Back-pressure: during the read response, out_ready toggles 1,0,0,1 → each byte held stable until its handshake, no byte lost or duplicated, then return to IDLE.
- Bad opcode 0x55 followed by a valid read frame → response FF, then a correct 82 response for the read.
- Timeout (TIMEOUT=16): write with waitrequest stuck at 1 → avm_write deasserted after 16 cycles → response EE → next frame works.
- Reset asserted after 2 address bytes → all outputs at reset values. A fresh write frame after reset completes normally with response 81.
